// File: rtl/ps2_kbd_emu.sv
// PS/2 keyboard device-side transmitter: serialises one Set-2 key event as [E0][F0]code frames.
// Define PS2_KBD_EMU_PARERR_EN to add par_err_i, which corrupts the code byte's parity bit.
module ps2_kbd_emu #(
  parameter int unsigned HALF_DIV   = 4,
  parameter int unsigned GAP_CYCLES = 10
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       key_valid_i,
  output logic       key_ready_o,
  input  logic [7:0] key_code_i,
  input  logic       key_ext_i,
  input  logic       key_release_i,
  input  logic       host_inhibit_i,
`ifdef PS2_KBD_EMU_PARERR_EN
  input  logic       par_err_i,
`endif
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy_o,
  output logic [7:0] abort_cnt_o
);

  localparam int unsigned SLOT_LEN  = 2 * HALF_DIV;
  localparam int unsigned CNT_W     = $clog2(SLOT_LEN);
  localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned STOP_SLOT = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_INH,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          code_q, code_d;
  logic                ext_q, ext_d;
  logic                rel_q, rel_d;
  logic                perr_q, perr_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                clk_q, clk_d;
  logic                data_q, data_d;
  logic [7:0]          abort_q, abort_d;

  logic [1:0]          nbytes_c;
  logic [7:0]          cur_byte_c;
  logic                inv_par_c;
  logic                accept_c;

  // Byte at position idx of the sequence [E0 if ext][F0 if release][code].
  function automatic logic [7:0] seq_byte(input logic [1:0] idx, input logic ext,
                                          input logic rel, input logic [7:0] code);
    logic [7:0] r;
    r = code;
    if (idx == 2'd0 && ext) begin
      r = 8'hE0;
    end else if (rel && ((idx == 2'd0 && !ext) || (idx == 2'd1 && ext))) begin
      r = 8'hF0;
    end
    return r;
  endfunction

  // Line level for a given slot: start, d0..d7, odd parity (optionally inverted), stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic inv,
                                     input logic [SLOT_W-1:0] slot);
    logic [10:0] frame;
    frame = {1'b1, ~(^b) ^ inv, b, 1'b0};
    return frame[slot];
  endfunction

  assign nbytes_c    = 2'd1 + 2'(ext_q) + 2'(rel_q);
  assign cur_byte_c  = seq_byte(byte_idx_q, ext_q, rel_q, code_q);
  assign inv_par_c   = perr_q && (byte_idx_q == nbytes_c - 2'd1);
  assign key_ready_o = (state_q == ST_IDLE) && !host_inhibit_i;
  assign accept_c    = key_valid_i && key_ready_o;
  assign busy_o      = (state_q != ST_IDLE);
  assign ps2_clk_o   = clk_q;
  assign ps2_data_o  = data_q;
  assign abort_cnt_o = abort_q;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    perr_d     = perr_q;
    byte_idx_d = byte_idx_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    clk_d      = clk_q;
    data_d     = data_q;
    abort_d    = abort_q;

    unique case (state_q)
      ST_IDLE: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (accept_c) begin
          code_d     = key_code_i;
          ext_d      = key_ext_i;
          rel_d      = key_release_i;
`ifdef PS2_KBD_EMU_PARERR_EN
          perr_d     = par_err_i;
`else
          perr_d     = 1'b0;
`endif
          byte_idx_d = 2'd0;
          state_d    = ST_WAIT_INH;
        end
      end

      ST_WAIT_INH: begin
        if (!host_inhibit_i) begin
          state_d = ST_SHIFT;
          slot_d  = '0;
          cnt_d   = '0;
          clk_d   = 1'b1;
          data_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (host_inhibit_i && slot_q != SLOT_W'(STOP_SLOT)) begin
          // Host grabbed the bus mid-frame: release lines, restart whole sequence later.
          clk_d      = 1'b1;
          data_d     = 1'b1;
          abort_d    = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
          byte_idx_d = 2'd0;
          gap_d      = '0;
          state_d    = ST_GAP;
        end else if (cnt_q == CNT_W'(SLOT_LEN - 1)) begin
          cnt_d = '0;
          clk_d = 1'b1;
          if (slot_q == SLOT_W'(STOP_SLOT)) begin
            data_d     = 1'b1;
            byte_idx_d = byte_idx_q + 2'd1;
            gap_d      = '0;
            state_d    = ST_GAP;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
            data_d = frame_bit(cur_byte_c, inv_par_c, slot_q + SLOT_W'(1));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
            clk_d = 1'b0;
          end
        end
      end

      ST_GAP: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (host_inhibit_i) begin
          gap_d = '0;
        end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          if (byte_idx_q < nbytes_c) begin
            state_d = ST_SHIFT;
            slot_d  = '0;
            cnt_d   = '0;
            data_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      perr_q     <= 1'b0;
      byte_idx_q <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      clk_q      <= 1'b1;
      data_q     <= 1'b1;
      abort_q    <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      perr_q     <= perr_d;
      byte_idx_q <= byte_idx_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      clk_q      <= clk_d;
      data_q     <= data_d;
      abort_q    <= abort_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_emu.sv
// Bench for ps2_kbd_emu: decodes the PS/2 lines at falling clock edges and compares
// against byte sequences and frame timing derived from the key-event rules.
module tb_ps2_kbd_emu;

  localparam int unsigned HALF_DIV   = 4;
  localparam int unsigned GAP_CYCLES = 10;
  localparam int unsigned SLOT       = 2 * HALF_DIV;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [7:0] key_code = 8'h00;
  logic       key_ext = 1'b0;
  logic       key_rel = 1'b0;
  logic       host_inh = 1'b0;
`ifdef PS2_KBD_EMU_PARERR_EN
  logic       par_err = 1'b0;
`endif
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] abort_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned cyc = 0;
  logic        prev_ps2_clk = 1'b1;
  logic        fall_bits[$];
  int unsigned fall_cyc[$];

  ps2_kbd_emu #(.HALF_DIV(HALF_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_i          (clk),
    .res_n_i        (res_n),
    .key_valid_i    (key_valid),
    .key_ready_o    (key_ready),
    .key_code_i     (key_code),
    .key_ext_i      (key_ext),
    .key_release_i  (key_rel),
    .host_inhibit_i (host_inh),
`ifdef PS2_KBD_EMU_PARERR_EN
    .par_err_i      (par_err),
`endif
    .ps2_clk_o      (ps2_clk),
    .ps2_data_o     (ps2_data),
    .busy_o         (busy),
    .abort_cnt_o    (abort_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver-side view: data bit and cycle of every falling PS/2 clock.
  always @(negedge clk) begin
    if (prev_ps2_clk && !ps2_clk) begin
      fall_bits.push_back(ps2_data);
      fall_cyc.push_back(cyc);
    end
    prev_ps2_clk <= ps2_clk;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time %0t reached, simulation limit exceeded", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic bq_t build_seq(input logic [7:0] code, input logic ext, input logic rel);
    bq_t q;
    q = {};
    if (ext) q.push_back(8'hE0);
    if (rel) q.push_back(8'hF0);
    q.push_back(code);
    return q;
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] b, input logic inv);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = 1'(int'(b) / (1 << i) % 2);
    f[9]  = 1'(($countones(b) % 2 == 0) ? 1 : 0) ^ inv;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic clear_mon();
    fall_bits.delete();
    fall_cyc.delete();
  endtask

  task automatic send(input logic [7:0] code, input logic ext, input logic rel,
                      input logic perr, output int unsigned acc);
    int t;
    t = 0;
    key_code  = code;
    key_ext   = ext;
    key_rel   = rel;
`ifdef PS2_KBD_EMU_PARERR_EN
    par_err   = perr;
`endif
    key_valid = 1'b1;
    while (!key_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!key_ready) check("send.ready_timeout", int'(key_ready), 1);
    @(negedge clk);
    key_valid = 1'b0;
    acc = cyc;
    if (perr) begin end
  endtask

  task automatic wait_idle(output int unsigned idle_c);
    int t;
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("wait_idle.timeout", int'(busy), 0);
    idle_c = cyc;
  endtask

  task automatic check_seq(input string name, input bq_t exp, input logic perr, input bit chk_time);
    int n;
    int bad;
    logic [10:0] act;
    n = exp.size();
    check({name, ".falls"}, fall_bits.size(), 11 * n);
    for (int k = 0; k < n; k++) begin
      if (fall_bits.size() >= 11 * (k + 1)) begin
        for (int i = 0; i < 11; i++) act[i] = fall_bits[11*k + i];
        check({name, ".frame"}, int'(act), int'(model_frame(exp[k], perr && (k == n - 1))));
      end
    end
    if (chk_time) begin
      bad = 0;
      for (int i = 1; i < fall_cyc.size(); i++) begin
        if (fall_cyc[i] - fall_cyc[i-1] != ((i % 11 == 0) ? SLOT + GAP_CYCLES : SLOT)) bad++;
      end
      check({name, ".spacing_errs"}, bad, 0);
    end
  endtask

  task automatic run_vec(input string name, input logic [7:0] code, input logic ext,
                         input logic rel, input logic perr, input bq_t exp);
    int unsigned acc;
    int unsigned idle_c;
    clear_mon();
    send(code, ext, rel, perr, acc);
    // Requests while busy must be ignored and must not disturb latched fields.
    key_code  = ~code;
    key_ext   = ~ext;
    key_rel   = ~rel;
    key_valid = 1'b1;
    repeat (30) @(negedge clk);
    key_valid = 1'b0;
    wait_idle(idle_c);
    check_seq(name, exp, perr, 1'b1);
    if (fall_cyc.size() > 0) begin
      check({name, ".first_fall_lat"}, int'(fall_cyc[0] - acc), 1 + HALF_DIV);
      check({name, ".ready_lat"}, int'(idle_c - fall_cyc[fall_cyc.size()-1]), HALF_DIV + GAP_CYCLES);
    end
    check({name, ".key_ready"}, int'(key_ready), 1);
  endtask

  initial begin
    vec_t        vecs[8];
    bq_t         q;
    int unsigned acc;
    int unsigned idle_c;
    int unsigned rel_edge;
    int          exp_abort;
    int          t;
    logic [7:0]  rc;
    logic        re;
    logic        rr;

    vecs[0] = '{code: 8'h04, ext: 1'b0, rel: 1'b0, n: 1, b0: 8'h04, b1: 8'h00, b2: 8'h00};
    vecs[1] = '{code: 8'h5A, ext: 1'b0, rel: 1'b1, n: 2, b0: 8'hF0, b1: 8'h5A, b2: 8'h00};
    vecs[2] = '{code: 8'h75, ext: 1'b1, rel: 1'b1, n: 3, b0: 8'hE0, b1: 8'hF0, b2: 8'h75};
    vecs[3] = '{code: 8'h76, ext: 1'b0, rel: 1'b1, n: 2, b0: 8'hF0, b1: 8'h76, b2: 8'h00};
    vecs[4] = '{code: 8'h1C, ext: 1'b0, rel: 1'b0, n: 1, b0: 8'h1C, b1: 8'h00, b2: 8'h00};
    vecs[5] = '{code: 8'h71, ext: 1'b1, rel: 1'b0, n: 2, b0: 8'hE0, b1: 8'h71, b2: 8'h00};
    vecs[6] = '{code: 8'h00, ext: 1'b0, rel: 1'b0, n: 1, b0: 8'h00, b1: 8'h00, b2: 8'h00};
    vecs[7] = '{code: 8'hFF, ext: 1'b0, rel: 1'b0, n: 1, b0: 8'hFF, b1: 8'h00, b2: 8'h00};
    exp_abort = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset.ps2_clk", int'(ps2_clk), 1);
    check("reset.ps2_data", int'(ps2_data), 1);
    check("reset.key_ready", int'(key_ready), 1);
    check("reset.busy", int'(busy), 0);
    check("reset.abort_cnt", int'(abort_cnt), 0);
    res_n = 1'b1;
    @(negedge clk);

    // Inhibit while idle blocks acceptance
    host_inh = 1'b1;
    @(negedge clk);
    check("idle_inh.key_ready", int'(key_ready), 0);
    host_inh = 1'b0;
    @(negedge clk);
    check("idle_inh.key_ready_back", int'(key_ready), 1);

    // Table-driven key events
    for (int v = 0; v < 8; v++) begin
      q = {};
      q.push_back(vecs[v].b0);
      if (vecs[v].n > 1) q.push_back(vecs[v].b1);
      if (vecs[v].n > 2) q.push_back(vecs[v].b2);
      run_vec($sformatf("vec%0d", v), vecs[v].code, vecs[v].ext, vecs[v].rel, 1'b0, q);
    end

    // Randomized key events against the sequence model
    for (int r = 0; r < 20; r++) begin
      rc = 8'($urandom_range(0, 255));
      re = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d_%02h_e%0d_r%0d", r, rc, re, rr), rc, re, rr, 1'b0,
              build_seq(rc, re, rr));
    end

    // Esc break: inhibit in slot 5 of F0 aborts, then full resend after GAP
    clear_mon();
    send(8'h76, 1'b0, 1'b1, 1'b0, acc);
    while (cyc < acc + 1 + 5 * SLOT + 2) @(negedge clk);
    host_inh = 1'b1;
    @(negedge clk);
    exp_abort++;
    check("abort.ps2_clk", int'(ps2_clk), 1);
    check("abort.ps2_data", int'(ps2_data), 1);
    check("abort.cnt", int'(abort_cnt), exp_abort);
    check("abort.falls_before", fall_bits.size(), 5);
    repeat (6) @(negedge clk);
    check("abort.lines_held", int'({ps2_clk, ps2_data}), 3);
    host_inh = 1'b0;
    rel_edge = cyc + 1;
    clear_mon();
    wait_idle(idle_c);
    check_seq("abort.resend", build_seq(8'h76, 1'b0, 1'b1), 1'b0, 1'b1);
    if (fall_cyc.size() > 0)
      check("abort.restart_lat", int'(fall_cyc[0] - rel_edge), GAP_CYCLES - 1 + HALF_DIV);

    // Inhibit during the stop slot is ignored
    clear_mon();
    send(8'h04, 1'b0, 1'b0, 1'b0, acc);
    while (cyc < acc + 1 + 10 * SLOT + 1) @(negedge clk);
    host_inh = 1'b1;
    repeat (3) @(negedge clk);
    host_inh = 1'b0;
    wait_idle(idle_c);
    check_seq("stop_inh", build_seq(8'h04, 1'b0, 1'b0), 1'b0, 1'b1);
    check("stop_inh.abort_cnt", int'(abort_cnt), exp_abort);

    // Inhibit in the inter-byte gap defers the next byte
    clear_mon();
    send(8'h5A, 1'b0, 1'b1, 1'b0, acc);
    while (cyc < acc + 1 + 11 * SLOT + 3) @(negedge clk);
    host_inh = 1'b1;
    repeat (20) @(negedge clk);
    check("gap_inh.lines_high", int'({ps2_clk, ps2_data}), 3);
    host_inh = 1'b0;
    rel_edge = cyc + 1;
    wait_idle(idle_c);
    check_seq("gap_inh", build_seq(8'h5A, 1'b0, 1'b1), 1'b0, 1'b0);
    check("gap_inh.abort_cnt", int'(abort_cnt), exp_abort);
    if (fall_cyc.size() > 11)
      check("gap_inh.deferred", int'(fall_cyc[11] > rel_edge), 1);

    // Asynchronous reset mid-slot releases the lines immediately
    clear_mon();
    send(8'h1C, 1'b0, 1'b0, 1'b0, acc);
    while (cyc < acc + 1 + HALF_DIV + 1) @(negedge clk);
    check("rst_mid.pre_clk_low", int'(ps2_clk), 0);
    res_n = 1'b0;
    #1;
    check("rst_mid.ps2_clk", int'(ps2_clk), 1);
    check("rst_mid.ps2_data", int'(ps2_data), 1);
    check("rst_mid.key_ready", int'(key_ready), 1);
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.abort_cnt", int'(abort_cnt), 0);
    exp_abort = 0;
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    run_vec("rst_mid.after", 8'h1C, 1'b0, 1'b0, 1'b0, build_seq(8'h1C, 1'b0, 1'b0));

    // Abort counter saturates at 255
    clear_mon();
    send(8'h1C, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 260; i++) begin
      t = 0;
      while (ps2_data !== 1'b0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      host_inh = 1'b1;
      @(negedge clk);
      host_inh = 1'b0;
      exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
      if (i == 9) check("sat.cnt_10", int'(abort_cnt), exp_abort);
    end
    check("sat.cnt_255", int'(abort_cnt), exp_abort);
    clear_mon();
    wait_idle(idle_c);
    check_seq("sat.final", build_seq(8'h1C, 1'b0, 1'b0), 1'b0, 1'b1);
    check("sat.cnt_hold", int'(abort_cnt), 255);

`ifdef PS2_KBD_EMU_PARERR_EN
    // Forced parity error hits only the code byte
    run_vec("parerr.1C", 8'h1C, 1'b0, 1'b0, 1'b1, build_seq(8'h1C, 1'b0, 1'b0));
    run_vec("parerr.E0F071", 8'h71, 1'b1, 1'b1, 1'b1, build_seq(8'h71, 1'b1, 1'b1));
    run_vec("parerr.off", 8'h1C, 1'b0, 1'b0, 1'b0, build_seq(8'h1C, 1'b0, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
